// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enabled single-port SRAM.
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BE_WIDTH       = DATA_WIDTH_DEF / 8;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_sp_be_array.sv
// Synchronous single-port storage with per-byte write enables; no reset.
module sram_sp_be_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  localparam int BE_W      = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_W-1:0]       be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds while a response is stalled
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_sp_be.sv
// Byte-enabled single-port SRAM with valid/ready request/response and zero-fill after reset.
//  state | meaning
//  INIT  | clearing the array one word per cycle (or skipping when INIT_ZERO=0)
//  READY | accepting requests
module sram_sp_be
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter bit INIT_ZERO  = 1'b1,
  localparam int BE_W      = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_W-1:0]       req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_err_q, rsp_rd_q;
  logic                  accept, in_range;
  logic                  arr_en, arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
  logic [BE_W-1:0]       arr_be;

  assign in_range  = {1'b0, req_addr} < DEPTH_L;
  assign req_ready = (state_q == READY) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign init_done = (state_q == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    arr_be    = req_be;
    case (state_q)
      INIT: begin
        if (INIT_ZERO) begin
          arr_en    = 1'b1;
          arr_we    = 1'b1;
          arr_addr  = cnt_q;
          arr_wdata = '0;
          arr_be    = '1;
          if (cnt_q == LAST) state_d = READY;
          else               cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = READY;
        end
      end
      READY: begin
        // out-of-range requests never touch the array
        arr_en = accept && in_range;
        arr_we = req_we;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !in_range;
      rsp_rd_q    <= !req_we && in_range;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && rsp_rd_q) ? arr_rdata : '0;

  sram_sp_be_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .be   (arr_be),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_sram_sp_be.sv
// Scoreboard bench for sram_sp_be at DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=12.
module tb_sram_sp_be;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 12;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   init_cycles;

  sram_sp_be #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .INIT_ZERO (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // monitor: every consumed response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  // present a request until accepted; leaves req_valid high, returns #1 after the accepting edge
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [BW-1:0] be, input logic [DW-1:0] er, input logic ee);
    int  n;
    bit  acc;
    n   = 0;
    acc = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    while (!acc && n < 60) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back('{rdata: er, err: ee});
        acc = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no acceptance in %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // counts edges from reset release until init_done; req_ready must stay low meanwhile
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      check("ready_in_init", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [DW-1:0] model_word(input int a);
    if (a == 3) return 32'hDE22BE44;
    if (a == 5) return 32'hCAFEF00D;
    return 32'h0;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);

    // release; a read of 11 is held during INIT and must be accepted once READY
    @(negedge clk);
    rst_n = 1'b1;
    fork
      wait_init(init_cycles);
      issue(1'b0, 4'd11, 32'h0, 4'h0, 32'h0, 1'b0);
    join
    idle();
    check("init_cycles", init_cycles, 32'd12);

    // byte-enable merge
    issue(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 4'd3, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    issue(1'b0, 4'd3, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    issue(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 4'd3, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    idle();

    // back-to-back write then read of the same address
    issue(1'b1, 4'd5, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 4'd5, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    idle();

    // out-of-range accesses
    issue(1'b1, 4'd13, 32'h00000001, 4'b1111, 32'h0, 1'b1);
    issue(1'b0, 4'd13, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b0, 4'd12, 32'h0, 4'h0, 32'h0, 1'b1);
    for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), 32'h0, 4'h0, model_word(a), 1'b0);
    idle();

    // response back-pressure, then overlapping hand-off
    rsp_ready = 1'b0;
    issue(1'b0, 4'd3, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    check("lat_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    req_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'hDE22BE44);
      check("stall_rsp_err", {31'b0, rsp_err}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    issue(1'b0, 4'd5, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    check("handoff_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("handoff_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    idle();
    check("handoff_drained", exp_q.size(), 32'd0);

    // reset while a response is pending
    rsp_ready = 1'b0;
    issue(1'b0, 4'd5, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd0);
    check("arst_init_done", {31'b0, init_done}, 32'd0);
    check("arst_rsp_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // reset again mid-INIT at cnt=6; INIT must restart and take a full 12 cycles
    repeat (6) @(posedge clk);
    #1;
    check("midinit_init_done", {31'b0, init_done}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midinit_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(init_cycles);
    check("reinit_cycles", init_cycles, 32'd12);

    // array must have been cleared by INIT
    issue(1'b0, 4'd3, 32'h0, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 4'd5, 32'h0, 4'h0, 32'h0, 1'b0);
    idle();
    idle();
    check("final_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
